// File: rtl/alu_mdu_ctrl_pkg.sv
// Shared ALU select codes, ALUOp and RV32M func3 codes, MDU FSM states and the base ALU decode.
package alu_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_PASS = 4'd10
  } alu_sel_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // I-type instructions carry immediate bits in [30], so only the shift-right form honours it.
  function automatic alu_sel_e decode_alu(logic [1:0] alu_op, logic [2:0] func3,
                                          logic ir_30, logic ir_5);
    logic [3:0] key;
    alu_sel_e   sel;
    key = {ir_30 & (ir_5 | (func3 == F3_DIVU)), func3};
    sel = ALU_PASS;
    case (alu_op)
      ALUOP_ADD:  sel = ALU_ADD;
      ALUOP_SUB:  sel = ALU_SUB;
      ALUOP_PASS: sel = ALU_PASS;
      default: begin
        case (key)
          4'b0000: sel = ALU_ADD;
          4'b1000: sel = ALU_SUB;
          4'b0100: sel = ALU_XOR;
          4'b0110: sel = ALU_OR;
          4'b0111: sel = ALU_AND;
          4'b0001: sel = ALU_SLL;
          4'b0101: sel = ALU_SRL;
          4'b1101: sel = ALU_SRA;
          4'b0010: sel = ALU_SLT;
          4'b0011: sel = ALU_SLTU;
          default: sel = ALU_PASS;
        endcase
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_mdu_ctrl_mdu_iter.sv
// Radix-2 multiply/divide step datapath holding the 2*XLEN accumulator {hi, lo}.
// Only built when M_EXT_EN is defined.
`ifdef M_EXT_EN
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] acc_next
);

  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   b_reg;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;

  // Multiply: conditional add into hi, then shift the whole accumulator right.
  assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, b_reg} : '0);
  // Divide: shift {rem, quo} left by one and try subtracting the divisor from rem.
  assign div_trial = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, b_reg};

  always_comb begin
    acc_next = {mul_sum, acc_reg[XLEN-1:1]};
    if (is_div) begin
      if (div_trial[XLEN]) begin
        acc_next = {acc_reg[2*XLEN-2:0], 1'b0};
      end else begin
        acc_next = {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      b_reg   <= '0;
    end else if (load) begin
      acc_reg <= {{XLEN{1'b0}}, a_mag};
      b_reg   <= b_mag;
    end else if (step) begin
      acc_reg <= acc_next;
    end
  end

endmodule
`endif

// File: rtl/alu_mdu_ctrl.sv
// EX-stage ALU select decode plus an iterative RV32M multiply/divide sequencer.
// Define M_EXT_EN to build the sequencer; without it the MDU outputs are tied to zero.
module alu_mdu_ctrl
  import alu_mdu_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALUSEL_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic                flush,
  input  logic [1:0]          ALUOp,
  input  logic [2:0]          func3,
  input  logic                IR_30,
  input  logic                IR_25,
  input  logic                IR_5,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  output logic [ALUSEL_W-1:0] ALUSel,
  output logic                is_mdu,
  output logic                mdu_busy,
  output logic                mdu_done,
  output logic [XLEN-1:0]     mdu_result
);

  logic     m_op;
  alu_sel_e alu_sel;

  // funct7 = 0000001 on an R-type op marks the M extension; the base ALU just passes.
  assign m_op = (ALUOp == ALUOP_FUNCT) & IR_5 & IR_25 & ~IR_30;

  always_comb begin
    alu_sel = decode_alu(ALUOp, func3, IR_30, IR_5);
    if (m_op) alu_sel = ALU_PASS;
  end

  assign ALUSel = ALUSEL_W'(alu_sel);

`ifdef M_EXT_EN
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        f3_reg;
  logic              neg_reg;
  logic              rem_neg_reg;
  logic              done_reg;
  logic [XLEN-1:0]   result_reg;
  logic              start;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, special_result, final_result;
  logic [XLEN-1:0]   quotient, remainder;
  logic [2*XLEN-1:0] acc_next, product;

  assign start    = (state_reg == ST_IDLE) & valid_in & m_op & ~flush;
  assign a_signed = (func3 == F3_MULH) | (func3 == F3_MULHSU) | (func3 == F3_DIV) | (func3 == F3_REM);
  assign b_signed = (func3 == F3_MULH) | (func3 == F3_DIV) | (func3 == F3_REM);
  assign a_neg    = a_signed & rs1[XLEN-1];
  assign b_neg    = b_signed & rs2[XLEN-1];
  assign a_mag    = a_neg ? -rs1 : rs1;
  assign b_mag    = b_neg ? -rs2 : rs2;
  assign div_zero = func3[2] & (rs2 == '0);
  assign div_ovf  = ((func3 == F3_DIV) | (func3 == F3_REM)) & (rs1 == MIN_NEG) & (rs2 == '1);
  // func3[1] separates REM* from DIV* among the divide ops.
  assign special_result = div_zero ? (func3[1] ? rs1 : '1) : (func3[1] ? '0 : rs1);

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .step     (state_reg == ST_RUN),
    .is_div   (f3_reg[2]),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc_next (acc_next)
  );

  assign product   = neg_reg ? -acc_next : acc_next;
  assign quotient  = neg_reg ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
  assign remainder = rem_neg_reg ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

  always_comb begin
    case (f3_reg)
      F3_MUL:                      final_result = product[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_result = product[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             final_result = quotient;
      default:                     final_result = remainder;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      f3_reg      <= '0;
      neg_reg     <= 1'b0;
      rem_neg_reg <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      if (flush) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              f3_reg      <= func3;
              neg_reg     <= a_neg ^ b_neg;
              rem_neg_reg <= a_neg;
              cnt_reg     <= '0;
              if (div_zero | div_ovf) begin
                result_reg <= special_result;
                done_reg   <= 1'b1;
                state_reg  <= ST_DONE;
              end else begin
                state_reg <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(XLEN - 1)) begin
              result_reg <= final_result;
              done_reg   <= 1'b1;
              state_reg  <= ST_DONE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign is_mdu     = m_op;
  assign mdu_busy   = start | (state_reg == ST_RUN);
  assign mdu_done   = done_reg;
  assign mdu_result = result_reg;
`else
  logic unused_mdu;
  assign unused_mdu = ^{clk, rst, valid_in, flush, rs1, rs2};

  assign is_mdu     = 1'b0;
  assign mdu_busy   = 1'b0;
  assign mdu_done   = 1'b0;
  assign mdu_result = '0;
`endif

endmodule

// File: doc/alu_mdu_ctrl.md
Name: alu_mdu_ctrl

Overview:
- Next-generation EX-stage ALU control for the RV32 core, parametrised in XLEN.
- Decodes base-ISA ALU selects combinationally, with the same mapping as the current ALU control.
- Adds RV32M decode and an internal iterative multiply/divide sequencer. The sequencer stalls the pipeline while it runs and returns a registered result.

Parameters:
- XLEN, 32, operand/result width; must be at least 8 and a power of two.
- ALUSEL_W, 4, width of ALUSel; must match the ALU_* codes in the shared defines.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  EX-stage instruction valid.
- flush  in  1  kill the EX instruction; aborts any MDU operation.
- ALUOp  in  2  from main control: 00 add, 01 sub, 10 funct-decoded, 11 pass.
- func3  in  3  instruction[14:12].
- IR_30  in  1  instruction[30].
- IR_25  in  1  instruction[25] (funct7[0], M-extension marker).
- IR_5  in  1  instruction[5] (1 = R-type, 0 = I-type).
- rs1  in  XLEN  operand A.
- rs2  in  XLEN  operand B.
- ALUSel  out  ALUSEL_W  base ALU select, combinational.
- is_mdu  out  1  EX instruction is an M-extension op, combinational.
- mdu_busy  out  1  stall request, combinational.
- mdu_done  out  1  one-cycle pulse; mdu_result valid.
- mdu_result  out  XLEN  registered MDU result.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high (clk, rst). On rst: state IDLE, counter 0, mdu_result 0, mdu_done 0. ALUSel and is_mdu are combinational and carry no reset value.
- ALUSel decode:
  - ALUOp 00 → ADD; 01 → SUB; 11 → PASS.
  - ALUOp 10, R-type uses {IR_30, func3}: 0000 ADD, 1000 SUB, 0100 XOR, 0110 OR, 0111 AND, 0001 SLL, 0101 SRL, 1101 SRA, 0010 SLT, 0011 SLTU, all others PASS.
  - ALUOp 10, I-type uses func3 only: 101 selects SRA if IR_30 is 1, else SRL.
- is_mdu = (ALUOp==10) & IR_5 & IR_25 & !IR_30. When is_mdu is 1, ALUSel = PASS.
- start = (state==IDLE) & valid_in & is_mdu & !flush. mdu_busy = start | (state==RUN).
- FSM states:
  - IDLE: on start, latch rs1, rs2 and func3, take operand magnitudes and sign flags, clear counter. Next state is DONE if a special case applies, else RUN.
  - RUN: one radix-2 step per cycle (shift-add for MUL*, restoring subtract for DIV*/REM*). Counter increments each cycle; on count==XLEN-1, next state is DONE.
  - DONE: mdu_done=1, mdu_result valid, mdu_busy=0 so the pipeline advances; next state IDLE. A start cannot fire in DONE, so the held instruction does not re-trigger.
- Latency: issue at cycle T, mdu_done at T+XLEN+1. Special cases finish at T+1.
- Special cases:
  - DIV/DIVU by zero: quotient all ones.
  - REM/REMU by zero: remainder = rs1.
  - Signed overflow (rs1 = 100…0, rs2 = all ones): DIV returns rs1, REM returns 0.
- Signs:
  - MULH is signed×signed; MULHSU is signed×unsigned.
  - Product is negated if the operand signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
- Result select by func3:
  - 000 → low XLEN bits of the product.
  - 001/010/011 → high XLEN bits of the product.
  - 100/101 → quotient.
  - 110/111 → remainder.
- flush in any state: next state IDLE, no mdu_done, mdu_result unchanged. If flush and rst are both asserted, rst wins.

Optional Feature:
- M_EXT_EN defined: the M-extension decode and sequencer are present, as described above.
- M_EXT_EN undefined: is_mdu is tied to 0, mdu_busy and mdu_done to 0, mdu_result to 0, and no sequencer logic is built. Instructions carrying funct7=0000001 decode ALUSel = PASS.

Decomposition:
- Shared defines: ALU_* select codes, MDU func3 codes (MUL through REMU), FSM state encodings, and the IR field macros.
- Sub-module mdu_iter holds the 2·XLEN accumulator and the step datapath, driven by the alu_mdu_ctrl FSM.

Test Plan:
- R-type decode sweep: ALUOp=10, IR_5=1, IR_25=0, all {IR_30, func3} combinations → ALUSel matches the table; 1001 → PASS; mdu_busy=0 throughout.
- MUL: rs1=7, rs2=-3 → busy for 33 cycles starting at issue; mdu_done at T+33; result 0xFFFFFFEB.
- MULHU: rs1=rs2=0xFFFFFFFF → result 0xFFFFFFFE. MULH on the same operands → 0x00000000.
- DIV: rs1=-20, rs2=3 → quotient 0xFFFFFFFA (-6). REM on the same operands → 0xFFFFFFFE (-2).
- Special cases: DIVU by 0 → 0xFFFFFFFF, done at T+1. DIV 0x80000000 / -1 → 0x80000000. REM for that overflow case → 0.
- flush at T+10 during DIV → IDLE next cycle, no done pulse. A back-to-back MUL after the flush completes normally. rst asserted mid-RUN → IDLE, mdu_result=0.
